// File: rtl/gray_pkg.sv
// Shared types and helpers for Gray-code receivers.
// Build option: GRAY_DEC_BACKWARD_EN (consumed by gray_decoder) makes downward steps legal.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        JUMP = 2'd3
    } step_t;

    // Zero-extended inputs decode correctly: leading zero Gray bits give zero binary bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder.
module gray2bin_comb #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    assign binary[WIDTH-1] = gray[WIDTH-1];

    // Each binary bit is the running XOR of all Gray bits at or above it.
    for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_xor
        assign binary[i] = binary[i+1] ^ gray[i];
    end

endmodule

// File: rtl/gray_decoder.sv
// Gray-code receiver: decodes, classifies each accepted sample, and tracks laps/overflow.
// Build option: define GRAY_DEC_BACKWARD_EN to accept -1 steps (otherwise they fault).
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT,
    parameter int LAP_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             Step,
    output logic             Dir,
    output logic             Err,
    output logic             Overflow,
    output logic [LAP_W-1:0] Laps
);

    localparam logic [WIDTH-1:0] CODE_MAX = '1;
    localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
    localparam logic [LAP_W-1:0] LAP_ONE  = LAP_W'(1);

    state_t           state, state_nxt;
    step_t            cls;
    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] binary_nxt;
    logic [LAP_W-1:0] laps_nxt;
    logic             locked_nxt, step_nxt, dir_nxt, err_nxt, ovf_nxt;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray   (Gray),
        .binary (b_new)
    );

    // Modular difference against the last accepted value picks the move class.
    assign delta = b_new - Binary;

    always_comb begin
        cls = JUMP;
        if (delta == '0)
            cls = HOLD;
        else if (delta == CODE_ONE)
            cls = UP;
        else if (delta == CODE_MAX)
            cls = DOWN;
    end

    always_comb begin
        state_nxt  = state;
        binary_nxt = Binary;
        locked_nxt = Locked;
        step_nxt   = 1'b0;
        dir_nxt    = Dir;
        err_nxt    = 1'b0;
        ovf_nxt    = Overflow;
        laps_nxt   = Laps;
        if (En) begin
            case (state)
                LOCKED: begin
                    case (cls)
                        HOLD: ;
                        UP: begin
                            binary_nxt = b_new;
                            step_nxt   = 1'b1;
                            dir_nxt    = 1'b1;
                            if (Binary == CODE_MAX && b_new == '0) begin
                                laps_nxt = Laps + LAP_ONE;
                                ovf_nxt  = 1'b1;
                            end
                        end
`ifdef GRAY_DEC_BACKWARD_EN
                        DOWN: begin
                            binary_nxt = b_new;
                            step_nxt   = 1'b1;
                            dir_nxt    = 1'b0;
                            if (Binary == '0 && b_new == CODE_MAX)
                                laps_nxt = Laps - LAP_ONE;
                        end
`endif
                        default: begin
                            err_nxt    = 1'b1;
                            locked_nxt = 1'b0;
                            state_nxt  = FAULT;
                        end
                    endcase
                end
                default: begin
                    // SYNC and FAULT both take the sample as a fresh reference.
                    binary_nxt = b_new;
                    locked_nxt = 1'b1;
                    state_nxt  = LOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= SYNC;
            Binary   <= '0;
            Locked   <= 1'b0;
            Step     <= 1'b0;
            Dir      <= 1'b1;
            Err      <= 1'b0;
            Overflow <= 1'b0;
            Laps     <= '0;
        end else begin
            state    <= state_nxt;
            Binary   <= binary_nxt;
            Locked   <= locked_nxt;
            Step     <= step_nxt;
            Dir      <= dir_nxt;
            Err      <= err_nxt;
            Overflow <= ovf_nxt;
            Laps     <= laps_nxt;
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder (WIDTH=3, LAP_W=8).
module tb_gray_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       En = 1'b0;
    logic [2:0] Gray = 3'b000;
    logic [2:0] Binary;
    logic       Locked, Step, Dir, Err, Overflow;
    logic [7:0] Laps;

    int vectors = 0;
    int errors  = 0;

    gray_decoder #(.WIDTH(3), .LAP_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Gray     (Gray),
        .Binary   (Binary),
        .Locked   (Locked),
        .Step     (Step),
        .Dir      (Dir),
        .Err      (Err),
        .Overflow (Overflow),
        .Laps     (Laps)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] g_of(input int n);
        logic [2:0] b;
        b = 3'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic apply(input logic [2:0] g);
        @(negedge Clk);
        En = 1'b1;
        Gray = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        En = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        vectors++; if (Binary !== 3'd0) begin $display("FAIL rst_binary: got %0d want 0", Binary); errors++; end
        vectors++; if (Locked !== 1'b0) begin $display("FAIL rst_locked: got %b want 0", Locked); errors++; end
        vectors++; if (Step !== 1'b0) begin $display("FAIL rst_step: got %b want 0", Step); errors++; end
        vectors++; if (Dir !== 1'b1) begin $display("FAIL rst_dir: got %b want 1", Dir); errors++; end
        vectors++; if (Err !== 1'b0) begin $display("FAIL rst_err: got %b want 0", Err); errors++; end
        vectors++; if (Overflow !== 1'b0) begin $display("FAIL rst_ovf: got %b want 0", Overflow); errors++; end
        vectors++; if (Laps !== 8'd0) begin $display("FAIL rst_laps: got %0d want 0", Laps); errors++; end
    endtask

    task automatic test_forward();
        logic [2:0] codes [9];
        codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        apply(codes[0]);
        vectors++; if (Binary !== 3'd0) begin $display("FAIL fwd_first_binary: got %0d want 0", Binary); errors++; end
        vectors++; if (Locked !== 1'b1) begin $display("FAIL fwd_first_locked: got %b want 1", Locked); errors++; end
        vectors++; if (Step !== 1'b0) begin $display("FAIL fwd_first_step: got %b want 0", Step); errors++; end
        for (int i = 1; i < 9; i++) begin
            apply(codes[i]);
            vectors++; if (Binary !== 3'(i % 8)) begin $display("FAIL fwd_binary[%0d]: got %0d want %0d", i, Binary, i % 8); errors++; end
            vectors++; if (Step !== 1'b1 || Dir !== 1'b1 || Err !== 1'b0) begin
                $display("FAIL fwd_flags[%0d]: got step=%b dir=%b err=%b want 1 1 0", i, Step, Dir, Err); errors++; end
            if (i == 7) begin
                vectors++; if (Overflow !== 1'b0 || Laps !== 8'd0) begin
                    $display("FAIL fwd_prewrap: got ovf=%b laps=%0d want 0 0", Overflow, Laps); errors++; end
            end
        end
        vectors++; if (Overflow !== 1'b1) begin $display("FAIL fwd_ovf: got %b want 1", Overflow); errors++; end
        vectors++; if (Laps !== 8'd1) begin $display("FAIL fwd_laps: got %0d want 1", Laps); errors++; end
    endtask

    task automatic test_jump();
        apply(3'b001);
        vectors++; if (Binary !== 3'd1 || Step !== 1'b1) begin $display("FAIL jmp_setup: got bin=%0d step=%b want 1 1", Binary, Step); errors++; end
        apply(3'b111);
        vectors++; if (Err !== 1'b1) begin $display("FAIL jmp_err: got %b want 1", Err); errors++; end
        vectors++; if (Locked !== 1'b0) begin $display("FAIL jmp_locked: got %b want 0", Locked); errors++; end
        vectors++; if (Binary !== 3'd1) begin $display("FAIL jmp_binary_hold: got %0d want 1", Binary); errors++; end
        vectors++; if (Step !== 1'b0) begin $display("FAIL jmp_step: got %b want 0", Step); errors++; end
        apply(3'b101);
        vectors++; if (Binary !== 3'd6) begin $display("FAIL jmp_resync_binary: got %0d want 6", Binary); errors++; end
        vectors++; if (Locked !== 1'b1 || Step !== 1'b0 || Err !== 1'b0) begin
            $display("FAIL jmp_resync_flags: got locked=%b step=%b err=%b want 1 0 0", Locked, Step, Err); errors++; end
        vectors++; if (Laps !== 8'd1 || Overflow !== 1'b1) begin
            $display("FAIL jmp_laps_kept: got laps=%0d ovf=%b want 1 1", Laps, Overflow); errors++; end
    endtask

    task automatic test_backward();
        apply(3'b011);
        vectors++; if (Err !== 1'b1) begin $display("FAIL bwd_setup_jump: got err=%b want 1", Err); errors++; end
        apply(3'b011);
        vectors++; if (Binary !== 3'd2 || Locked !== 1'b1) begin
            $display("FAIL bwd_setup_lock: got bin=%0d locked=%b want 2 1", Binary, Locked); errors++; end
        apply(3'b001);
`ifdef GRAY_DEC_BACKWARD_EN
        vectors++; if (Binary !== 3'd1 || Step !== 1'b1 || Dir !== 1'b0 || Err !== 1'b0) begin
            $display("FAIL bwd_down: got bin=%0d step=%b dir=%b err=%b want 1 1 0 0", Binary, Step, Dir, Err); errors++; end
        apply(3'b000);
        vectors++; if (Binary !== 3'd0 || Step !== 1'b1) begin $display("FAIL bwd_to0: got bin=%0d step=%b want 0 1", Binary, Step); errors++; end
        apply(3'b100);
        vectors++; if (Binary !== 3'd7 || Dir !== 1'b0) begin $display("FAIL bwd_wrap_bin: got bin=%0d dir=%b want 7 0", Binary, Dir); errors++; end
        vectors++; if (Laps !== 8'd0) begin $display("FAIL bwd_wrap_laps: got %0d want 0", Laps); errors++; end
        vectors++; if (Overflow !== 1'b1) begin $display("FAIL bwd_wrap_ovf: got %b want 1", Overflow); errors++; end
`else
        vectors++; if (Err !== 1'b1 || Locked !== 1'b0 || Binary !== 3'd2) begin
            $display("FAIL bwd_down_fault: got err=%b locked=%b bin=%0d want 1 0 2", Err, Locked, Binary); errors++; end
        vectors++; if (Dir !== 1'b1) begin $display("FAIL bwd_dir_const: got %b want 1", Dir); errors++; end
        apply(3'b000);
        vectors++; if (Binary !== 3'd0 || Locked !== 1'b1) begin $display("FAIL bwd_resync: got bin=%0d locked=%b want 0 1", Binary, Locked); errors++; end
        apply(3'b100);
        vectors++; if (Err !== 1'b1 || Binary !== 3'd0) begin $display("FAIL bwd_wrap_fault: got err=%b bin=%0d want 1 0", Err, Binary); errors++; end
        vectors++; if (Laps !== 8'd1 || Overflow !== 1'b1) begin
            $display("FAIL bwd_wrap_laps: got laps=%0d ovf=%b want 1 1", Laps, Overflow); errors++; end
`endif
    endtask

    task automatic test_hold_en();
        logic [2:0] idle_codes [3];
        idle_codes = '{3'b000, 3'b101, 3'b111};
        pulse_reset();
        apply(3'b010);
        vectors++; if (Binary !== 3'd3 || Locked !== 1'b1 || Step !== 1'b0) begin
            $display("FAIL hold_sync: got bin=%0d locked=%b step=%b want 3 1 0", Binary, Locked, Step); errors++; end
        for (int i = 0; i < 3; i++) begin
            apply(3'b010);
            vectors++; if (Step !== 1'b0 || Err !== 1'b0 || Binary !== 3'd3) begin
                $display("FAIL hold[%0d]: got step=%b err=%b bin=%0d want 0 0 3", i, Step, Err, Binary); errors++; end
        end
        apply(3'b110);
        vectors++; if (Binary !== 3'd4 || Step !== 1'b1) begin $display("FAIL hold_step: got bin=%0d step=%b want 4 1", Binary, Step); errors++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            En = 1'b0;
            Gray = idle_codes[i];
            @(posedge Clk);
            #1;
            vectors++; if (Binary !== 3'd4 || Step !== 1'b0 || Err !== 1'b0 || Locked !== 1'b1) begin
                $display("FAIL en_gate[%0d]: got bin=%0d step=%b err=%b locked=%b want 4 0 0 1", i, Binary, Step, Err, Locked); errors++; end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        apply(3'b000);
        for (int n = 1; n <= 21; n++) apply(g_of(n));
        vectors++; if (Binary !== 3'd5 || Laps !== 8'd2 || Overflow !== 1'b1) begin
            $display("FAIL arst_pre: got bin=%0d laps=%0d ovf=%b want 5 2 1", Binary, Laps, Overflow); errors++; end
        #1;
        Reset = 1'b1;
        #1;
        vectors++; if (Binary !== 3'd0 || Locked !== 1'b0 || Step !== 1'b0 || Dir !== 1'b1 ||
                       Err !== 1'b0 || Overflow !== 1'b0 || Laps !== 8'd0) begin
            $display("FAIL arst_immediate: got bin=%0d lk=%b st=%b dir=%b err=%b ovf=%b laps=%0d want 0 0 0 1 0 0 0",
                     Binary, Locked, Step, Dir, Err, Overflow, Laps); errors++; end
        #1;
        Reset = 1'b0;
        apply(3'b110);
        vectors++; if (Binary !== 3'd4 || Locked !== 1'b1 || Step !== 1'b0 || Err !== 1'b0) begin
            $display("FAIL arst_first: got bin=%0d locked=%b step=%b err=%b want 4 1 0 0", Binary, Locked, Step, Err); errors++; end
    endtask

    task automatic test_lap_wrap();
        int wraps = 0;
        for (int k = 1; k <= 2048; k++) begin
            apply(g_of((4 + k) % 8));
            if ((4 + k) % 8 == 0) begin
                wraps++;
                if (wraps == 1) begin
                    vectors++; if (Laps !== 8'd1 || Overflow !== 1'b1) begin
                        $display("FAIL lap_first: got laps=%0d ovf=%b want 1 1", Laps, Overflow); errors++; end
                end
                if (wraps == 255) begin
                    vectors++; if (Laps !== 8'd255) begin $display("FAIL lap_255: got %0d want 255", Laps); errors++; end
                end
            end
        end
        vectors++; if (Laps !== 8'd0) begin $display("FAIL lap_wrap: got %0d want 0", Laps); errors++; end
        vectors++; if (Overflow !== 1'b1) begin $display("FAIL lap_ovf_sticky: got %b want 1", Overflow); errors++; end
        vectors++; if (Binary !== 3'd4 || Step !== 1'b1) begin $display("FAIL lap_end: got bin=%0d step=%b want 4 1", Binary, Step); errors++; end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_jump();
        test_backward();
        test_hold_en();
        test_async_reset();
        test_lap_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
